tc_io_master: RTL and testbench

//  Bus initiator for the timer/counter I/O register interface: the CPU-side end of the tc bus.

---
 rtl/tc_io_master.sv | 199 +++++++++++++++++++
 tb/tb_tc_io_master.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_io_master.sv
// CPU-side initiator of the timer/counter register bus: queues register commands, issues them
// as single-cycle strobes, buffers read responses and acknowledges interrupts under the I bit.
`timescale 1ns/1ps
module tc_io_master #(
    parameter int CMD_DEPTH = 4,
    parameter int IRQ_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [7:0]           cmd_addr,
    input  logic [7:0]           cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_addr,
    output logic [7:0]           rsp_data,
    output logic [7:0]           addr,
    output logic                 read,
    output logic                 write,
    output logic [7:0]           wdata,
    input  logic [7:0]           rdata,
    input  logic                 interrupt_request,
    output logic                 interrupt_executed,
    output logic                 status_reg_interrupt_enable,
    output logic [IRQ_CNT_W-1:0] irq_count,
    output logic                 busy
);

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_SEI   = 2'd2,
        OP_CLI   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_ACK
    } state_e;

    typedef struct packed {
        op_e        op;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    localparam int AW = $clog2(CMD_DEPTH);
    localparam logic [AW-1:0]        PTR_ONE  = AW'(1);
    localparam logic [AW:0]          CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]          CNT_FULL = (AW + 1)'(CMD_DEPTH);
    localparam logic [IRQ_CNT_W-1:0] IRQ_ONE  = IRQ_CNT_W'(1);

    cmd_t          fifo_mem [CMD_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    cmd_t          head;

    state_e        state;
    state_e        state_next;
    op_e           cur_op;
    logic          irq_take;
    logic          head_issuable;

    logic          read_next;
    logic          write_next;
    logic          irq_exec_next;
    logic [7:0]    addr_next;
    logic [7:0]    wdata_next;
    logic          ie_next;

    // ---------------- command FIFO ----------------
    assign fifo_full  = (fifo_cnt == CNT_FULL);
    assign fifo_empty = (fifo_cnt == '0);
    assign cmd_ready  = !rst && !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign head       = fifo_mem[rd_ptr];

    // NOTE: the storage array has no reset; fifo_cnt alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{op: op_e'(cmd_op), addr: cmd_addr, wdata: cmd_wdata};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: ;
            endcase
        end
    end

    // ---------------- FSM ----------------
    // A READ may only leave the queue if the response buffer is free by the time it returns.
    assign head_issuable = (head.op != OP_READ) || !rsp_valid || rsp_ready;
    assign irq_take      = (state == S_IDLE) && interrupt_request && status_reg_interrupt_enable;
    assign pop           = (state == S_IDLE) && !irq_take && !fifo_empty && head_issuable;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cur_op <= OP_WRITE;
        end else begin
            state <= state_next;
            if (pop) cur_op <= head.op;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (irq_take)  state_next = S_ACK;
                else if (pop)  state_next = S_ISSUE;
            end
            S_ISSUE: state_next = S_IDLE;
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Next values of the registered bus outputs, decided while leaving IDLE.
    always_comb begin
        // NOTE: every output gets a default up front, so no path can infer a latch.
        read_next     = pop && (head.op == OP_READ);
        write_next    = pop && (head.op == OP_WRITE);
        irq_exec_next = irq_take;
        addr_next     = addr;
        wdata_next    = wdata;
        ie_next       = status_reg_interrupt_enable;
        if (read_next || write_next) addr_next = head.addr;
        if (write_next)              wdata_next = head.wdata;
        if (state == S_ACK) begin
            ie_next = 1'b0;
        end else if (state == S_ISSUE) begin
            if (cur_op == OP_SEI)      ie_next = 1'b1;
            else if (cur_op == OP_CLI) ie_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read                        <= 1'b0;
            write                       <= 1'b0;
            interrupt_executed          <= 1'b0;
            addr                        <= '0;
            wdata                       <= '0;
            status_reg_interrupt_enable <= 1'b0;
        end else begin
            read                        <= read_next;
            write                       <= write_next;
            interrupt_executed          <= irq_exec_next;
            addr                        <= addr_next;
            wdata                       <= wdata_next;
            status_reg_interrupt_enable <= ie_next;
        end
    end

    // ---------------- response buffer and interrupt counter ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            irq_count <= '0;
        end else begin
            if (state == S_ISSUE && cur_op == OP_READ) begin
                rsp_valid <= 1'b1;
                rsp_addr  <= addr;
                rsp_data  <= rdata;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            if (state == S_ACK && irq_count != '1) begin
                irq_count <= irq_count + IRQ_ONE;
            end
        end
    end

    assign busy = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_tc_io_master.sv
// Self-checking bench for tc_io_master: directed timing scenarios plus a randomized command
// stream scored against a register-file model of the responder.
`timescale 1ns/1ps
module tb_tc_io_master;

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_SEI   = 2'd2;
    localparam logic [1:0] OP_CLI   = 2'd3;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_addr;
    logic [7:0]  rsp_data;
    logic [7:0]  addr;
    logic        read;
    logic        write;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        interrupt_request;
    logic        interrupt_executed;
    logic        status_reg_interrupt_enable;
    logic [15:0] irq_count;
    logic        busy;

    logic        rsp_ready_dir;
    logic        rsp_rand_en;
    logic        rsp_rand_bit;

    tc_io_master #(.CMD_DEPTH(4), .IRQ_CNT_W(16)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .cmd_valid                   (cmd_valid),
        .cmd_ready                   (cmd_ready),
        .cmd_op                      (cmd_op),
        .cmd_addr                    (cmd_addr),
        .cmd_wdata                   (cmd_wdata),
        .rsp_valid                   (rsp_valid),
        .rsp_ready                   (rsp_ready),
        .rsp_addr                    (rsp_addr),
        .rsp_data                    (rsp_data),
        .addr                        (addr),
        .read                        (read),
        .write                       (write),
        .wdata                       (wdata),
        .rdata                       (rdata),
        .interrupt_request           (interrupt_request),
        .interrupt_executed          (interrupt_executed),
        .status_reg_interrupt_enable (status_reg_interrupt_enable),
        .irq_count                   (irq_count),
        .busy                        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    assign rsp_ready = rsp_rand_en ? rsp_rand_bit : rsp_ready_dir;

    initial begin
        rsp_rand_bit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_rand_bit = 1'($urandom_range(0, 1));
        end
    end

    // Responder register file: answers reads combinationally, takes writes on the strobe.
    logic [7:0] resp_mem [256];
    assign rdata = resp_mem[addr];

    initial begin
        for (int i = 0; i < 256; i++) resp_mem[i] = 8'(i) ^ 8'hC3;
        forever begin
            @(posedge clk);
            if (!rst && write) resp_mem[addr] = wdata;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q [$];
    ev_t        rsp_q [$];
    logic [7:0] model_mem [256];
    logic       model_ie;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ack_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_push(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        case (op)
            OP_WRITE: begin
                exp_q.push_back('{op: op, addr: a, data: d});
                model_mem[a] = d;
            end
            OP_READ: begin
                exp_q.push_back('{op: op, addr: a, data: 8'h00});
                rsp_q.push_back('{op: op, addr: a, data: model_mem[a]});
            end
            OP_SEI:  model_ie = 1'b1;
            default: model_ie = 1'b0;
        endcase
    endtask

    // Monitor: scores every bus strobe and every consumed response against the queues.
    initial begin
        ev_t        e;
        logic       prev_hold;
        logic [7:0] prev_addr;
        logic [7:0] prev_data;
        prev_hold = 1'b0;
        prev_addr = '0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (interrupt_executed) ack_cycles++;
                if (read || write || interrupt_executed)
                    check("strobe_exclusive", 32'(read) + 32'(write) + 32'(interrupt_executed), 1);
                if (read || write) begin
                    check("strobe_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("bus_op", read ? 32'(OP_READ) : 32'(OP_WRITE), 32'(e.op));
                        check("bus_addr", 32'(addr), 32'(e.addr));
                        if (write) check("bus_wdata", 32'(wdata), 32'(e.data));
                    end
                end
                if (prev_hold) begin
                    check("rsp_hold_valid", 32'(rsp_valid), 1);
                    check("rsp_hold_addr", 32'(rsp_addr), 32'(prev_addr));
                    check("rsp_hold_data", 32'(rsp_data), 32'(prev_data));
                end
                if (rsp_valid && rsp_ready) begin
                    check("rsp_expected", 32'(rsp_q.size() != 0), 1);
                    if (rsp_q.size() != 0) begin
                        e = rsp_q.pop_front();
                        check("rsp_addr", 32'(rsp_addr), 32'(e.addr));
                        check("rsp_data", 32'(rsp_data), 32'(e.data));
                    end
                end
                prev_hold = rsp_valid && !rsp_ready;
                prev_addr = rsp_addr;
                prev_data = rsp_data;
            end
        end
    end

    // ---------------- stimulus helpers (all start and end 1 ns after a rising edge) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        bit ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        cmd_valid = 1'b0;
        check("cmd_accepted", 32'(ok), 1);
        if (ok) model_push(op, a, d);
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (done) tick();
        check("drain_done", 32'(done), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_addr"}, 32'(rsp_addr), 0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 0);
        check({tag, "_addr"}, 32'(addr), 0);
        check({tag, "_wdata"}, 32'(wdata), 0);
        check({tag, "_strobes"}, 32'(read) + 32'(write) + 32'(interrupt_executed), 0);
        check({tag, "_ie"}, 32'(status_reg_interrupt_enable), 0);
        check({tag, "_irq_count"}, 32'(irq_count), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         ack_base;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] d;

        rst               = 1'b1;
        cmd_valid         = 1'b0;
        cmd_op            = '0;
        cmd_addr          = '0;
        cmd_wdata         = '0;
        interrupt_request = 1'b0;
        rsp_ready_dir     = 1'b0;
        rsp_rand_en       = 1'b0;
        model_ie          = 1'b0;
        for (int i = 0; i < 256; i++) model_mem[i] = 8'(i) ^ 8'hC3;

        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(cmd_ready), 1);
        tick();

        // Single write into an idle block: strobe two cycles after the push.
        push_cmd(OP_WRITE, 8'h25, 8'h01);
        @(negedge clk); check("t1_no_early_write", 32'(write), 0);
        @(negedge clk); check("t1_write", 32'(write), 1);
        check("t1_addr", 32'(addr), 32'h25);
        check("t1_wdata", 32'(wdata), 32'h01);
        check("t1_no_read", 32'(read), 0);
        @(negedge clk); check("t1_write_one_cycle", 32'(write), 0);
        tick();

        // Read with the response held, then drained.
        push_cmd(OP_WRITE, 8'h26, 8'h5A);
        wait_idle(20);
        push_cmd(OP_READ, 8'h26, 8'h00);
        @(negedge clk); check("t2_rsp_not_yet", 32'(rsp_valid), 0);
        @(negedge clk); check("t2_read", 32'(read), 1);
        @(negedge clk); check("t2_rsp_valid", 32'(rsp_valid), 1);
        check("t2_rsp_addr", 32'(rsp_addr), 32'h26);
        check("t2_rsp_data", 32'(rsp_data), 32'h5A);
        repeat (4) begin
            @(negedge clk);
            check("t2_rsp_held", 32'(rsp_valid), 1);
            check("t2_rsp_held_data", 32'(rsp_data), 32'h5A);
        end
        tick();
        rsp_ready_dir = 1'b1;
        @(negedge clk); check("t2_rsp_present", 32'(rsp_valid), 1);
        tick();
        rsp_ready_dir = 1'b0;
        @(negedge clk); check("t2_rsp_dropped", 32'(rsp_valid), 0);
        tick();

        // Head-of-line stall behind an unconsumed response.
        push_cmd(OP_READ, 8'h30, 8'h00);
        repeat (3) tick();
        @(negedge clk); check("t3_rsp_pending", 32'(rsp_valid), 1);
        tick();
        push_cmd(OP_READ, 8'h27, 8'h00);
        push_cmd(OP_WRITE, 8'h6E, 8'h07);
        repeat (6) begin
            @(negedge clk);
            check("t3_stalled", 32'(read) + 32'(write), 0);
        end
        check("t3_busy", 32'(busy), 1);
        tick();
        rsp_ready_dir = 1'b1;
        @(negedge clk); check("t3_c0_idle", 32'(read) + 32'(write), 0);
        @(negedge clk); check("t3_read", 32'(read), 1);
        check("t3_read_addr", 32'(addr), 32'h27);
        @(negedge clk); check("t3_gap", 32'(read) + 32'(write), 0);
        @(negedge clk); check("t3_write", 32'(write), 1);
        check("t3_write_addr", 32'(addr), 32'h6E);
        check("t3_write_data", 32'(wdata), 32'h07);
        tick();
        wait_idle(20);
        rsp_ready_dir = 1'b0;

        // FIFO fills to four entries; the fifth waits until a pop.
        push_cmd(OP_READ, 8'h21, 8'h00);
        repeat (3) tick();
        push_cmd(OP_READ, 8'h22, 8'h00);
        push_cmd(OP_WRITE, 8'h23, 8'h99);
        push_cmd(OP_SEI, 8'h00, 8'h00);
        push_cmd(OP_READ, 8'h24, 8'h00);
        @(negedge clk); check("t4_full", 32'(cmd_ready), 0);
        tick();
        cmd_valid = 1'b1;
        cmd_op    = OP_CLI;
        repeat (3) begin
            @(negedge clk);
            check("t4_fifth_blocked", 32'(cmd_ready), 0);
            tick();
        end
        rsp_ready_dir = 1'b1;
        push_cmd(OP_CLI, 8'h00, 8'h00);
        wait_idle(50);
        check("t4_ie", 32'(status_reg_interrupt_enable), 32'(model_ie));

        // Interrupt acknowledge, no re-ack while held, re-armed by SEI.
        push_cmd(OP_SEI, 8'h00, 8'h00);
        wait_idle(20);
        check("t5_ie_set", 32'(status_reg_interrupt_enable), 1);
        ack_base = ack_cycles;
        interrupt_request = 1'b1;
        repeat (8) tick();
        model_ie = 1'b0;
        check("t5_one_pulse", 32'(ack_cycles - ack_base), 1);
        check("t5_ie_cleared", 32'(status_reg_interrupt_enable), 32'(model_ie));
        check("t5_irq_count", 32'(irq_count), 1);
        push_cmd(OP_SEI, 8'h00, 8'h00);
        repeat (8) tick();
        model_ie = 1'b0;
        check("t5_second_pulse", 32'(ack_cycles - ack_base), 2);
        check("t5_irq_count2", 32'(irq_count), 2);
        check("t5_ie_cleared2", 32'(status_reg_interrupt_enable), 32'(model_ie));
        interrupt_request = 1'b0;
        tick();

        // Interrupt wins over a queued write in the same idle cycle.
        push_cmd(OP_SEI, 8'h00, 8'h00);
        wait_idle(20);
        push_cmd(OP_WRITE, 8'h28, 8'h3C);
        interrupt_request = 1'b1;
        @(negedge clk); check("t6_n1", 32'(interrupt_executed) + 32'(write), 0);
        tick();
        interrupt_request = 1'b0;
        @(negedge clk); check("t6_ack", 32'(interrupt_executed), 1);
        check("t6_no_write_in_ack", 32'(write), 0);
        @(negedge clk); check("t6_gap", 32'(interrupt_executed) + 32'(write), 0);
        @(negedge clk); check("t6_write", 32'(write), 1);
        check("t6_write_addr", 32'(addr), 32'h28);
        tick();
        model_ie = 1'b0;
        wait_idle(20);
        check("t6_irq_count", 32'(irq_count), 3);

        // Randomized command stream with random response back-pressure.
        rsp_rand_en = 1'b1;
        for (int n = 0; n < 150; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = 8'h20 + 8'($urandom_range(0, 7));
            d  = 8'($urandom);
            push_cmd(op, a, d);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
        end
        rsp_rand_en   = 1'b0;
        rsp_ready_dir = 1'b1;
        wait_idle(200);
        check("rand_bus_drained", 32'(exp_q.size()), 0);
        check("rand_rsp_drained", 32'(rsp_q.size()), 0);
        check("rand_ie", 32'(status_reg_interrupt_enable), 32'(model_ie));
        check("rand_irq_count", 32'(irq_count), 3);

        // Reset during the issue cycle of a read.
        rsp_ready_dir = 1'b0;
        push_cmd(OP_READ, 8'h22, 8'h00);
        tick();
        check("rst_read_active", 32'(read), 1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_all_zero("midrst");
        tick();
        rst = 1'b0;
        exp_q.delete();
        rsp_q.delete();
        model_ie = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_rsp_valid", 32'(rsp_valid), 0);
            tick();
        end
        check("post_rst_ready", 32'(cmd_ready), 1);
        check("post_rst_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
